uart_byte_tx: RTL and testbench
===============================

UART_BYTE_TX -- requirements
Module: uart_byte_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (legal range 2..65535).
REQ-002 The block SHALL have parameter STOP_BITS, default 1, number of stop bits per frame (legal values 1 or 2).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as the codebase does: `clk_out1` and `rst`.
REQ-004 The port `clk_out1` SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-005 The port `rst` SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-006 The port `din` SHALL be an input, 8 bits wide: byte from the upstream sample buffer.
REQ-007 The port `din_valid` SHALL be an input, 1 bit wide: `din` holds a byte offered for transmission.
REQ-008 The port `din_ready` SHALL be an output, 1 bit wide: the block can accept a byte this cycle.
REQ-009 The port `tx` SHALL be an output, 1 bit wide: serial line, idle high.
REQ-010 The port `busy` SHALL be an output, 1 bit wide: a frame is in progress or a byte is held.
REQ-011 The port `frame_done` SHALL be an output, 1 bit wide: one-cycle pulse at the end of each frame.

Function
REQ-012 A byte SHALL be accepted on a rising edge where `din_valid`=1 and `din_ready`=1; `din` is captured into a one-entry holding register; `din` is ignored at all other times.
REQ-013 `din_ready` SHALL equal NOT(holding register full); it does not depend combinationally on `din_valid`.
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP; IDLE->START on the first edge where the holding register is full, moving the byte into the shift register and emptying the holding register.
REQ-015 Latency SHALL be exactly one cycle: a byte accepted at edge N while in IDLE drives `tx`=0 from edge N+1.
REQ-016 START SHALL drive `tx`=0 for CLKS_PER_BIT cycles, then move to DATA.
REQ-017 DATA SHALL shift 8 bits LSB first, each held for exactly CLKS_PER_BIT cycles, then move to STOP.
REQ-018 STOP SHALL drive `tx`=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-019 At the end of STOP, the FSM SHALL go directly to START if the holding register is full (zero idle gap); otherwise it SHALL go to IDLE.
REQ-020 `frame_done` SHALL be 1 during exactly the last cycle of STOP.
REQ-021 In a cycle where the holding register transfers to the shifter and a new byte is accepted, the new byte SHALL occupy the holding register and no byte is lost or duplicated.
REQ-022 `busy` SHALL be 1 when the state is not IDLE or the holding register is full.
REQ-023 The bit-period counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and wrap to 0 at each bit boundary.
REQ-024 The bit index SHALL be 3 bits wide and wrap after bit 7.
REQ-025 `tx` SHALL be driven from a register; it is glitch-free.

Reset
REQ-026 Asserting `rst`=0 SHALL immediately force: state IDLE, `tx`=1, `din_ready`=1, `busy`=0, `frame_done`=0, all counters 0, holding register empty.
REQ-027 Reset mid-frame SHALL abort the frame; the held byte is discarded and no further bits of that frame are sent.
REQ-028 On reset release, the block SHALL accept a byte on the first rising edge where `rst`=1.

Structure
REQ-029 Package `uart_pkg` SHALL hold the FSM state enum, default CLKS_PER_BIT, and the IDLE_LEVEL=1'b1 constant.
REQ-030 Bit timing SHALL be a sub-module `uart_bit_timer` (counter plus a `bit_end` strobe, restartable).
REQ-031 The top SHALL contain the holding register, shift register and FSM.

Verification
REQ-032 The bench SHALL run with CLKS_PER_BIT=4 and STOP_BITS=1 unless noted.
REQ-033 Single byte: send 0xA5 from IDLE -> `tx`=0,1,0,1,0,0,1,0,1,1, each held 4 cycles; 40 cycles total; `frame_done` pulses once in cycle 40.
REQ-034 Back-to-back: offer 0x00, then 0xFF immediately -> 80 contiguous frame cycles with no high gap between the stop bit and the second start bit.
REQ-035 Backpressure: hold `din_valid`=1 with three bytes -> `din_ready`=0 while the holding register is full; bytes appear on `tx` in order; none lost.
REQ-036 Reset mid-frame: drive `rst`=0 during DATA bit 3 -> `tx`=1 and `busy`=0 without waiting for a clock edge; the next accepted byte is sent with a correct full frame.
REQ-037 STOP_BITS=2: send 0x3C -> frame is 44 cycles long, with `tx`=1 for the last 8 cycles.
REQ-038 Simultaneous transfer and accept: present a new byte on the edge IDLE->START -> the new byte is held, then transmitted immediately after the first frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the byte-wide UART transmitter.
// Holds the frame FSM states and the serial-line idle level.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    // 100 MHz clock at 115200 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and strobes bit_end on the last cycle.
// Held at zero while clear is high, so every frame starts on a fresh bit period.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk_out1,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign bit_end = !clear && (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_out1 or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: one-entry holding register in front of a shift-register FSM.
// Back-to-back bytes leave the stop bit straight into the next start bit.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk_out1,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    state_t     state, state_d;
    logic [7:0] hold, hold_d;
    logic       hold_full, hold_full_d;
    logic [7:0] shift, shift_d;
    logic [2:0] bit_idx, bit_idx_d;
    logic       tx_q, tx_d;
    logic       bit_end;
    logic       last_stop;
    logic       accept;
    logic       load;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk_out1(clk_out1),
        .rst     (rst),
        .clear   (state == ST_IDLE),
        .bit_end (bit_end)
    );

    assign din_ready  = !hold_full;
    assign accept     = din_valid && !hold_full;
    assign last_stop  = (state == ST_STOP) && bit_end && (bit_idx == LAST_STOP);
    assign frame_done = last_stop;
    assign busy       = (state != ST_IDLE) || hold_full;
    assign tx         = tx_q;

    // NOTE: every signal gets its default before the case, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state;
        hold_d      = hold;
        hold_full_d = hold_full;
        shift_d     = shift;
        bit_idx_d   = bit_idx;
        load        = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (hold_full) begin
                    state_d = ST_START;
                    load    = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d   = {1'b0, shift[7:1]};
                    bit_idx_d = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (last_stop) begin
                    bit_idx_d = '0;
                    if (hold_full) begin
                        state_d = ST_START;
                        load    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (bit_end) begin
                    bit_idx_d = bit_idx + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Accept needs an empty holder and load needs a full one, so they never collide.
        if (load) begin
            shift_d     = hold;
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_d      = din;
            hold_full_d = 1'b1;
        end

        // The line level is registered from the next state, keeping tx glitch-free.
        unique case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk_out1 or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            shift     <= '0;
            bit_idx   <= '0;
            tx_q      <= IDLE_LEVEL;
        end else begin
            state     <= state_d;
            hold      <= hold_d;
            hold_full <= hold_full_d;
            shift     <= shift_d;
            bit_idx   <= bit_idx_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Self-checking bench for uart_byte_tx: frames are predicted from byte lists by
// plain arithmetic (bit k of a frame lasts CPB cycles) and compared cycle by cycle.
module tb_uart_byte_tx;

    localparam int CPB = 4;

    logic       clk_out1 = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] din      = 8'h00;
    logic       din_valid = 1'b0;
    logic       sel2     = 1'b0;

    logic din_valid_a, din_valid_b;
    logic ready_a, tx_a, busy_a, done_a;
    logic ready_b, tx_b, busy_b, done_b;
    logic o_ready, o_tx, o_busy, o_done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] bytes_q[$];

    assign din_valid_a = din_valid && !sel2;
    assign din_valid_b = din_valid && sel2;

    assign o_ready = sel2 ? ready_b : ready_a;
    assign o_tx    = sel2 ? tx_b    : tx_a;
    assign o_busy  = sel2 ? busy_b  : busy_a;
    assign o_done  = sel2 ? done_b  : done_a;

    uart_byte_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk_out1  (clk_out1),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid_a),
        .din_ready (ready_a),
        .tx        (tx_a),
        .busy      (busy_a),
        .frame_done(done_a)
    );

    uart_byte_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_stop2 (
        .clk_out1  (clk_out1),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid_b),
        .din_ready (ready_b),
        .tx        (tx_b),
        .busy      (busy_b),
        .frame_done(done_b)
    );

    always #5 clk_out1 = ~clk_out1;

    // Reference: the byte list is accepted at edge N, sample 0 is the cycle after N,
    // frames follow each other from sample 1 with no gap; byte k+1 waits in the holder
    // from the second cycle of frame k until frame k+1 begins.
    function automatic void exp_sample(input int s, input int sb, input int n,
                                       output logic e_tx, output logic e_done,
                                       output logic e_busy, output logic e_ready);
        int f, j, k, p, b;
        logic [7:0] v;
        f = (9 + sb) * CPB;
        if (s == 0) begin
            e_tx = 1'b1; e_done = 1'b0; e_busy = 1'b1; e_ready = 1'b0;
        end else begin
            j = s - 1;
            k = j / f;
            p = j % f;
            if (k < n) begin
                b = p / CPB;
                v = bytes_q[k];
                if (b == 0)      e_tx = 1'b0;
                else if (b <= 8) e_tx = v[b-1];
                else             e_tx = 1'b1;
                e_done  = (p == f - 1);
                e_busy  = 1'b1;
                e_ready = !((k + 1 < n) && (p >= 1));
            end else begin
                e_tx = 1'b1; e_done = 1'b0; e_busy = 1'b0; e_ready = 1'b1;
            end
        end
    endfunction

    // Streams bytes_q with din_valid held high whenever a byte remains.
    task automatic run_stream(input string name, input int sb);
        int   n, f, total, next;
        logic acc;
        logic e_tx, e_done, e_busy, e_ready;
        n     = bytes_q.size();
        f     = (9 + sb) * CPB;
        total = 1 + n * f + 4;
        @(negedge clk_out1);
        din       = bytes_q[0];
        din_valid = 1'b1;
        n_cmp++;
        if (o_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s first_ready: got %b want 1", name, o_ready);
        end
        @(posedge clk_out1);
        #1;
        next = 1;
        if (next < n) din = bytes_q[next];
        else begin din_valid = 1'b0; din = 8'($urandom); end
        for (int s = 0; s < total; s++) begin
            @(negedge clk_out1);
            exp_sample(s, sb, n, e_tx, e_done, e_busy, e_ready);
            n_cmp += 4;
            if (o_tx !== e_tx) begin
                n_bad++;
                $display("FAIL %s tx @%0d: got %b want %b", name, s, o_tx, e_tx);
            end
            if (o_done !== e_done) begin
                n_bad++;
                $display("FAIL %s frame_done @%0d: got %b want %b", name, s, o_done, e_done);
            end
            if (o_busy !== e_busy) begin
                n_bad++;
                $display("FAIL %s busy @%0d: got %b want %b", name, s, o_busy, e_busy);
            end
            if (o_ready !== e_ready) begin
                n_bad++;
                $display("FAIL %s din_ready @%0d: got %b want %b", name, s, o_ready, e_ready);
            end
            acc = din_valid && o_ready;
            @(posedge clk_out1);
            #1;
            if (acc) begin
                next++;
                if (next < n) din = bytes_q[next];
                else begin din_valid = 1'b0; din = 8'($urandom); end
            end else if (!din_valid) begin
                din = 8'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #20;
        n_cmp += 4;
        if (o_tx !== 1'b1)    begin n_bad++; $display("FAIL reset tx: got %b want 1", o_tx); end
        if (o_ready !== 1'b1) begin n_bad++; $display("FAIL reset din_ready: got %b want 1", o_ready); end
        if (o_busy !== 1'b0)  begin n_bad++; $display("FAIL reset busy: got %b want 0", o_busy); end
        if (o_done !== 1'b0)  begin n_bad++; $display("FAIL reset frame_done: got %b want 0", o_done); end
        // Byte offered on the very first edge after release must be taken.
        @(negedge clk_out1);
        rst       = 1'b1;
        din       = 8'($urandom);
        din_valid = 1'b1;
        @(posedge clk_out1);
        #1 din_valid = 1'b0;
        n_cmp += 2;
        if (o_ready !== 1'b0) begin n_bad++; $display("FAIL release_accept din_ready: got %b want 0", o_ready); end
        if (o_busy !== 1'b1)  begin n_bad++; $display("FAIL release_accept busy: got %b want 1", o_busy); end
        repeat (44) @(negedge clk_out1);
        n_cmp += 2;
        if (o_tx !== 1'b1)   begin n_bad++; $display("FAIL release_idle tx: got %b want 1", o_tx); end
        if (o_busy !== 1'b0) begin n_bad++; $display("FAIL release_idle busy: got %b want 0", o_busy); end
    endtask

    task automatic test_single();
        bytes_q = {8'hA5};
        run_stream("single_a5", 1);
    endtask

    task automatic test_back_to_back();
        bytes_q = {8'h00, 8'hFF};
        run_stream("back_to_back", 1);
    endtask

    task automatic test_backpressure();
        bytes_q = {8'($urandom), 8'($urandom), 8'($urandom)};
        run_stream("backpressure", 1);
    endtask

    task automatic test_transfer_accept();
        bytes_q = {8'($urandom), 8'($urandom)};
        run_stream("transfer_accept", 1);
    endtask

    task automatic test_mid_reset();
        logic [7:0] b;
        b = 8'($urandom) & 8'hF7;
        @(negedge clk_out1);
        din       = b;
        din_valid = 1'b1;
        @(posedge clk_out1);
        #1 din_valid = 1'b0;
        repeat (19) @(negedge clk_out1);
        n_cmp++;
        if (o_tx !== 1'b0) begin n_bad++; $display("FAIL mid_reset data_bit3: got %b want 0", o_tx); end
        #2 rst = 1'b0;
        #1;
        n_cmp += 4;
        if (o_tx !== 1'b1)    begin n_bad++; $display("FAIL mid_reset tx: got %b want 1", o_tx); end
        if (o_busy !== 1'b0)  begin n_bad++; $display("FAIL mid_reset busy: got %b want 0", o_busy); end
        if (o_ready !== 1'b1) begin n_bad++; $display("FAIL mid_reset din_ready: got %b want 1", o_ready); end
        if (o_done !== 1'b0)  begin n_bad++; $display("FAIL mid_reset frame_done: got %b want 0", o_done); end
        repeat (3) @(posedge clk_out1);
        #2 rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_out1);
            n_cmp += 2;
            if (o_tx !== 1'b1)   begin n_bad++; $display("FAIL mid_reset_after tx @%0d: got %b want 1", i, o_tx); end
            if (o_busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_after busy @%0d: got %b want 0", i, o_busy); end
        end
        bytes_q = {8'($urandom)};
        run_stream("post_reset_frame", 1);
    endtask

    task automatic test_stop2();
        sel2 = 1'b1;
        bytes_q = {8'h3C};
        run_stream("stop2_3c", 2);
        bytes_q = {8'($urandom), 8'($urandom)};
        run_stream("stop2_pair", 2);
        sel2 = 1'b0;
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 4; it++) begin
            n = int'($urandom_range(1, 3));
            bytes_q = {};
            for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom));
            repeat ($urandom_range(0, 5)) @(posedge clk_out1);
            run_stream($sformatf("random_%0d", it), 1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_transfer_accept();
        test_mid_reset();
        test_stop2();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
